// File: rtl/led_sequencer.sv
// LED pattern sequencer: prescaled stepping through rotate-left, rotate-right,
// ping-pong and flash/hold modes. Define LED_SEQUENCER_FLASH_EN to enable mode-11 flashing.
module led_sequencer #(
    parameter int NB_LEDS     = 4,
    parameter int NB_PRESCALE = 24
) (
    input  logic                   clock,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic [1:0]             i_mode,
    input  logic [NB_PRESCALE-1:0] i_limit,
    output logic [NB_LEDS-1:0]     o_led,
    output logic                   o_tick,
    output logic                   o_wrap
);

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

    localparam logic [NB_LEDS-1:0] LED_INIT  = NB_LEDS'(1);
    localparam logic [1:0]         MODE_ROL  = 2'b00;
    localparam logic [1:0]         MODE_ROR  = 2'b01;
    localparam logic [1:0]         MODE_PING = 2'b10;

    logic [NB_PRESCALE-1:0] count_reg;
    logic [NB_LEDS-1:0]     led_reg;
    dir_t                   dir_reg;
    logic [1:0]             mode_reg;
    logic                   tick_reg;
    logic                   wrap_reg;

    logic [NB_LEDS-1:0]     step_led;
    dir_t                   step_dir;
    logic                   step_wrap;

    // Pattern that a step would produce from the current state.
    always_comb begin
        step_led  = led_reg;
        step_dir  = dir_reg;
        step_wrap = 1'b0;
        case (mode_reg)
            MODE_ROL: begin
                step_led  = {led_reg[NB_LEDS-2:0], led_reg[NB_LEDS-1]};
                step_wrap = led_reg[NB_LEDS-1];
            end
            MODE_ROR: begin
                step_led  = {led_reg[0], led_reg[NB_LEDS-1:1]};
                step_wrap = led_reg[0];
            end
            MODE_PING: begin
                // Reverse on the step that reaches an end, so no end LED repeats.
                if (dir_reg == UP) begin
                    step_led = led_reg << 1;
                    if (led_reg[NB_LEDS-2]) begin
                        step_dir  = DOWN;
                        step_wrap = 1'b1;
                    end
                end else begin
                    step_led = led_reg >> 1;
                    if (led_reg[1]) begin
                        step_dir  = UP;
                        step_wrap = 1'b1;
                    end
                end
            end
            default: begin
`ifdef LED_SEQUENCER_FLASH_EN
                step_led  = (&led_reg) ? '0 : '1;
                step_wrap = &led_reg;
`else
                step_led  = led_reg;
                step_wrap = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            count_reg <= '0;
            led_reg   <= LED_INIT;
            dir_reg   <= UP;
            mode_reg  <= MODE_ROL;
            tick_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else if (i_mode != mode_reg) begin
            // Mode change restarts the sequence even while disabled.
            count_reg <= '0;
            led_reg   <= LED_INIT;
            dir_reg   <= UP;
            mode_reg  <= i_mode;
            tick_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else if (i_enable) begin
            if (count_reg >= i_limit) begin
                count_reg <= '0;
                led_reg   <= step_led;
                dir_reg   <= step_dir;
                tick_reg  <= 1'b1;
                wrap_reg  <= step_wrap;
            end else begin
                count_reg <= count_reg + 1'b1;
                tick_reg  <= 1'b0;
                wrap_reg  <= 1'b0;
            end
        end else begin
            tick_reg <= 1'b0;
            wrap_reg <= 1'b0;
        end
    end

    assign o_led  = led_reg;
    assign o_tick = tick_reg;
    assign o_wrap = wrap_reg;

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: position/step-count model compared every
// cycle, plus directed literal sequences. Honours LED_SEQUENCER_FLASH_EN.
module tb_led_sequencer;

    localparam int N  = 4;
    localparam int NP = 8;

    logic          clock = 1'b0;
    logic          i_reset;
    logic          i_enable;
    logic [1:0]    i_mode;
    logic [NP-1:0] i_limit;
    logic [N-1:0]  o_led;
    logic          o_tick;
    logic          o_wrap;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    led_sequencer #(.NB_LEDS(N), .NB_PRESCALE(NP)) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_mode   (i_mode),
        .i_limit  (i_limit),
        .o_led    (o_led),
        .o_tick   (o_tick),
        .o_wrap   (o_wrap)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: lit LED index, ping-pong heading, cycles since last step, flash step count.
    int m_pos, m_cnt, m_fsteps;
    bit m_up, m_tick, m_wrap;
    int m_mode;

    always @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            m_pos <= 0; m_up <= 1'b1; m_cnt <= 0; m_mode <= 0;
            m_fsteps <= 0; m_tick <= 1'b0; m_wrap <= 1'b0;
        end else if (int'(i_mode) != m_mode) begin
            m_mode <= int'(i_mode); m_pos <= 0; m_up <= 1'b1; m_cnt <= 0;
            m_fsteps <= 0; m_tick <= 1'b0; m_wrap <= 1'b0;
        end else if (!i_enable) begin
            m_tick <= 1'b0; m_wrap <= 1'b0;
        end else if (m_cnt < int'(i_limit)) begin
            m_cnt <= m_cnt + 1; m_tick <= 1'b0; m_wrap <= 1'b0;
        end else begin
            m_cnt  <= 0;
            m_tick <= 1'b1;
            case (m_mode)
                0: begin m_pos <= (m_pos + 1) % N;     m_wrap <= (m_pos == N - 1); end
                1: begin m_pos <= (m_pos + N - 1) % N; m_wrap <= (m_pos == 0);     end
                2: begin
                    if (m_up) begin
                        m_pos  <= m_pos + 1;
                        m_wrap <= (m_pos + 1 == N - 1);
                        if (m_pos + 1 == N - 1) m_up <= 1'b0;
                    end else begin
                        m_pos  <= m_pos - 1;
                        m_wrap <= (m_pos - 1 == 0);
                        if (m_pos - 1 == 0) m_up <= 1'b1;
                    end
                end
                default: begin
                    m_fsteps <= m_fsteps + 1;
`ifdef LED_SEQUENCER_FLASH_EN
                    m_wrap <= ((m_fsteps + 1) % 2 == 0);
`else
                    m_wrap <= 1'b0;
`endif
                end
            endcase
        end
    end

    function automatic logic [31:0] exp_led();
        logic [31:0] ones;
        ones = (32'd1 << N) - 32'd1;
        if (m_mode == 3) begin
`ifdef LED_SEQUENCER_FLASH_EN
            if (m_fsteps == 0) return 32'd1;
            return (m_fsteps % 2 == 1) ? ones : 32'd0;
`else
            return 32'd1;
`endif
        end
        return 32'd1 << m_pos;
    endfunction

    always @(negedge clock) begin
        if (check_en) begin
            check("model_led",  32'(o_led),  exp_led());
            check("model_tick", 32'(o_tick), 32'(m_tick));
            check("model_wrap", 32'(o_wrap), 32'(m_wrap));
        end
    end

    logic [3:0] rol_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] pp_seq  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0100, 4'b0010, 4'b0001, 4'b0010};

    initial begin
        i_reset = 1'b0; i_enable = 1'b1; i_mode = 2'b00; i_limit = '0;
        repeat (2) @(negedge clock);
        check("reset_led",  32'(o_led),  32'h1);
        check("reset_tick", 32'(o_tick), 32'h0);
        check("reset_wrap", 32'(o_wrap), 32'h0);
        check_en = 1'b1;
        i_reset  = 1'b1;

        // Rotate left, step every cycle.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            $display("rol step %0d: led=%b tick=%b wrap=%b", k, o_led, o_tick, o_wrap);
            check("rol_led",  32'(o_led),  32'(rol_seq[k]));
            check("rol_tick", 32'(o_tick), 32'h1);
            check("rol_wrap", 32'(o_wrap), (k == 3) ? 32'h1 : 32'h0);
        end

        // Ping-pong, each pattern held three cycles.
        i_mode = 2'b10; i_limit = 8'd2;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge clock);
                check("pp_led",  32'(o_led),  32'(pp_seq[k]));
                check("pp_tick", 32'(o_tick), (j == 0 && k != 0) ? 32'h1 : 32'h0);
                check("pp_wrap", 32'(o_wrap), (j == 0 && (k == 3 || k == 6)) ? 32'h1 : 32'h0);
            end
            $display("pp step %0d: led=%b", k, o_led);
        end

        // Rotate right with an enable hold, then a limit lowered below the count.
        i_mode = 2'b01; i_limit = 8'd3;
        repeat (6) @(negedge clock);
        i_enable = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            check("hold_tick", 32'(o_tick), 32'h0);
            check("hold_wrap", 32'(o_wrap), 32'h0);
        end
        $display("hold: led=%b", o_led);
        i_enable = 1'b1;
        repeat (8) @(negedge clock);
        i_limit = 8'd7;
        repeat (5) @(negedge clock);
        i_limit = 8'd1;
        repeat (4) @(negedge clock);

        // Mode change from rotate-left at 0100 to rotate-right.
        i_mode = 2'b00; i_limit = 8'd0;
        @(negedge clock); check("mc_reload", 32'(o_led), 32'h1);
        @(negedge clock); check("mc_led1",   32'(o_led), 32'h2);
        @(negedge clock); check("mc_led2",   32'(o_led), 32'h4);
        i_mode = 2'b01;
        @(negedge clock);
        check("mc_switch_led",  32'(o_led),  32'h1);
        check("mc_switch_tick", 32'(o_tick), 32'h0);
        @(negedge clock);
        $display("mode change: led=%b tick=%b wrap=%b", o_led, o_tick, o_wrap);
        check("mc_first_led",  32'(o_led),  32'h8);
        check("mc_first_wrap", 32'(o_wrap), 32'h1);

        // Asynchronous reset pulsed between edges.
        i_mode = 2'b00; i_limit = 8'd3;
        repeat (6) @(negedge clock);
        check("pre_reset_led", 32'(o_led), 32'h2);
        #2 i_reset = 1'b0;
        #1;
        check("async_led",  32'(o_led),  32'h1);
        check("async_tick", 32'(o_tick), 32'h0);
        check("async_wrap", 32'(o_wrap), 32'h0);
        @(negedge clock);
        i_reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            check("post_reset_led",  32'(o_led),  (j == 3) ? 32'h2 : 32'h1);
            check("post_reset_tick", 32'(o_tick), (j == 3) ? 32'h1 : 32'h0);
        end
        $display("post reset: led=%b", o_led);

        // Mode 11, step every two cycles.
        i_mode = 2'b11; i_limit = 8'd1;
        @(negedge clock);
        check("flash_entry", 32'(o_led), 32'h1);
        for (int j = 1; j <= 6; j++) begin
            @(negedge clock);
            check("flash_tick", 32'(o_tick), (j % 2 == 0) ? 32'h1 : 32'h0);
`ifdef LED_SEQUENCER_FLASH_EN
            check("flash_led",  32'(o_led),  (j < 2) ? 32'h1 : ((j == 2 || j == 3 || j == 6) ? 32'hF : 32'h0));
            check("flash_wrap", 32'(o_wrap), (j == 4) ? 32'h1 : 32'h0);
`else
            check("flash_led",  32'(o_led),  32'h1);
            check("flash_wrap", 32'(o_wrap), 32'h0);
`endif
            $display("flash cycle %0d: led=%b tick=%b wrap=%b", j, o_led, o_tick, o_wrap);
        end
        i_mode = 2'b00;
        @(negedge clock);
        check("flash_exit", 32'(o_led), 32'h1);

        // Random stress against the model, with occasional mid-cycle resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            if ($urandom_range(0, 15) == 0) i_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)  i_limit = 8'($urandom_range(0, 4));
            i_enable = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 80) == 0) begin
                #2 i_reset = 1'b0;
                #1 i_reset = 1'b1;
            end
        end
        @(negedge clock);
        check_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
